hanoi_move_gen: RTL and testbench

HANOI_MOVE_GEN -- requirements
Module: hanoi_move_gen

---
 rtl/hanoi_pkg.sv | 29 ++
 rtl/hanoi_move_gen_if.sv | 26 ++
 rtl/hanoi_ctz.sv | 18 +
 rtl/hanoi_move_gen.sv | 130 +++++++++++++
 tb/tb_hanoi_move_gen.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/hanoi_pkg.sv
// Shared types and width helpers for the Tower-of-Hanoi move generator.
package hanoi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CALC,
    ST_OFFER,
    ST_SETTLE,
    ST_DONE
  } state_e;

  typedef enum logic {
    DIR_LEFT,
    DIR_RIGHT
  } dir_e;

  localparam int DEF_RINGS = 3;
  localparam int DEF_PEGS  = 3;

  // Widths never collapse to zero so single-peg or single-ring builds still elaborate.
  function automatic int peg_w(input int m);
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/hanoi_move_gen_if.sv
// Move handshake between the generator (master) and the downstream hanoi block (slave).
interface hanoi_move_gen_if #(
  parameter int IW = 2,
  parameter int PW = 2
) ();

  logic [IW-1:0] ind;
  logic [PW-1:0] loc;
  logic          move_valid;
  logic          move_ready;

  modport master (
    output ind,
    output loc,
    output move_valid,
    input  move_ready
  );

  modport slave (
    input  ind,
    input  loc,
    input  move_valid,
    output move_ready
  );

endinterface

// File: rtl/hanoi_ctz.sv
// Combinational trailing-zero count; an all-zero input reports N-1.
module hanoi_ctz #(
  parameter int N  = 3,
  parameter int IW = 2
) (
  input  logic [N-1:0]  val_i,
  output logic [IW-1:0] ctz_o
);

  // Scan downward so the lowest set bit wins.
  always_comb begin
    ctz_o = IW'(N - 1);
    for (int i = N - 1; i >= 0; i--) begin
      if (val_i[i]) ctz_o = IW'(i);
    end
  end

endmodule

// File: rtl/hanoi_move_gen.sv
// Iterative optimal Tower-of-Hanoi move generator with a valid/ready move port.
module hanoi_move_gen
  import hanoi_pkg::*;
#(
  parameter  int N  = DEF_RINGS,
  parameter  int M  = DEF_PEGS,
  localparam int W  = peg_w(M),
  localparam int IW = idx_w(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [N*W-1:0]   rings,
  hanoi_move_gen_if.master mv,
  output logic [N-1:0]     move_count,
  output logic             done
);

  localparam logic [N-1:0] K_LAST = {N{1'b1}};
  localparam logic [W-1:0] PEG_MAX = W'(M - 1);

  state_e        state_q, state_d;
  logic [N-1:0]  k_q, k_d;
  logic [IW-1:0] ind_q, ind_d;
  logic [W-1:0]  loc_q, loc_d;
  logic          valid_q, valid_d;
  logic          done_q, done_d;

  logic [IW-1:0] tz;
  logic [W-1:0]  old_peg;

  function automatic dir_e ring_dir(input logic [IW-1:0] idx);
    return (((N - int'(idx)) % 2) != 0) ? DIR_LEFT : DIR_RIGHT;
  endfunction

  function automatic logic [W-1:0] step_peg(input logic [W-1:0] old, input dir_e dir);
    if (dir == DIR_LEFT) return (old == '0) ? PEG_MAX : old - W'(1);
    return (old == PEG_MAX) ? '0 : old + W'(1);
  endfunction

  hanoi_ctz #(
    .N  (N),
    .IW (IW)
  ) u_ctz (
    .val_i (k_q),
    .ctz_o (tz)
  );

  always_comb begin
    old_peg = '0;
    for (int i = 0; i < N; i++) begin
      if (tz == IW'(i)) old_peg = rings[i*W +: W];
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    ind_d   = ind_q;
    loc_d   = loc_q;
    valid_d = valid_q;
    done_d  = done_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          k_d     = N'(1);
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        ind_d   = tz;
        loc_d   = step_peg(old_peg, ring_dir(tz));
        valid_d = 1'b1;
        state_d = ST_OFFER;
      end
      ST_OFFER: begin
        if (mv.move_ready) begin
          valid_d = 1'b0;
          if (k_q == K_LAST) begin
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            k_d     = k_q + N'(1);
            state_d = ST_SETTLE;
          end
        end
      end
      // One idle cycle lets the downstream block apply the move before rings is sampled again.
      ST_SETTLE: begin
        state_d = ST_CALC;
      end
      ST_DONE: begin
        if (start) begin
          done_d  = 1'b0;
          k_d     = N'(1);
          state_d = ST_CALC;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      ind_q   <= '0;
      loc_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      ind_q   <= ind_d;
      loc_q   <= loc_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  // k already reads 0 in IDLE and 2^N-1 in DONE, so it doubles as the move counter.
  assign mv.ind        = ind_q;
  assign mv.loc        = loc_q;
  assign mv.move_valid = valid_q;
  assign move_count    = k_q;
  assign done          = done_q;

endmodule

// File: tb/tb_hanoi_move_gen.sv
// Directed bench for hanoi_move_gen with N=3, M=3 and a small ring-position model.
module tb_hanoi_move_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [5:0] rings;
  logic [2:0] move_count;
  logic       done;
  int         peg [3];
  int         total = 0;
  int         bad   = 0;

  hanoi_move_gen_if #(.IW(2), .PW(2)) mv_if ();

  hanoi_move_gen #(.N(3), .M(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .rings      (rings),
    .mv         (mv_if.master),
    .move_count (move_count),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive_rings();
    rings = {2'(peg[2]), 2'(peg[1]), 2'(peg[0])};
  endtask

  task automatic wait_offer();
    for (int i = 0; i < 8; i++) begin
      if (mv_if.move_valid) break;
      tick();
    end
    chk("offer_seen", int'(mv_if.move_valid), 1);
  endtask

  task automatic take(input int ei, input int el, input int ek);
    wait_offer();
    chk($sformatf("ind_k%0d", ek), int'(mv_if.ind), ei);
    chk($sformatf("loc_k%0d", ek), int'(mv_if.loc), el);
    chk($sformatf("cnt_k%0d", ek), int'(move_count), ek);
    mv_if.move_ready = 1'b1;
    tick();
    peg[ei] = el;
    drive_rings();
    chk($sformatf("vld_after_k%0d", ek), int'(mv_if.move_valid), 0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_vld"}, int'(mv_if.move_valid), 0);
    chk({tag, "_ind"}, int'(mv_if.ind), 0);
    chk({tag, "_loc"}, int'(mv_if.loc), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_cnt"}, int'(move_count), 0);
  endtask

  initial begin
    rst = 1'b0;
    start = 1'b0;
    mv_if.move_ready = 1'b0;
    peg[0] = 0; peg[1] = 0; peg[2] = 0;
    drive_rings();
    repeat (3) tick();
    chk_reset("rst");

    // First start honoured on the first edge after reset release.
    rst = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("calc_cnt", int'(move_count), 1);
    chk("calc_vld", int'(mv_if.move_valid), 0);
    tick();
    chk("m1_vld", int'(mv_if.move_valid), 1);
    chk("m1_ind", int'(mv_if.ind), 0);
    chk("m1_loc", int'(mv_if.loc), 2);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_vld", int'(mv_if.move_valid), 1);
      chk("stall_ind", int'(mv_if.ind), 0);
      chk("stall_loc", int'(mv_if.loc), 2);
      chk("stall_cnt", int'(move_count), 1);
    end
    mv_if.move_ready = 1'b1;
    tick();
    peg[0] = 2;
    drive_rings();
    chk("m1_settle_vld", int'(mv_if.move_valid), 0);
    chk("m1_settle_cnt", int'(move_count), 2);

    take(1, 1, 2);

    // Start pulsed while move 3 is on offer must be ignored.
    wait_offer();
    chk("m3_ind", int'(mv_if.ind), 0);
    chk("m3_loc", int'(mv_if.loc), 1);
    chk("m3_cnt", int'(move_count), 3);
    mv_if.move_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("m3_hold_vld", int'(mv_if.move_valid), 1);
    chk("m3_hold_ind", int'(mv_if.ind), 0);
    chk("m3_hold_loc", int'(mv_if.loc), 1);
    chk("m3_hold_cnt", int'(move_count), 3);
    mv_if.move_ready = 1'b1;
    tick();
    peg[0] = 1;
    drive_rings();
    chk("m3_settle_cnt", int'(move_count), 4);

    take(2, 2, 4);

    // Now in SETTLE after move 4: reset abandons the solve.
    rst = 1'b0;
    tick();
    chk_reset("midrst");
    tick();
    chk("midrst_hold_vld", int'(mv_if.move_valid), 0);
    rst = 1'b1;
    peg[0] = 0; peg[1] = 0; peg[2] = 0;
    drive_rings();
    start = 1'b1;
    tick();
    start = 1'b0;
    take(0, 2, 1);
    take(1, 1, 2);
    take(0, 1, 3);
    take(2, 2, 4);
    take(0, 0, 5);
    take(1, 2, 6);
    take(0, 2, 7);
    chk("done_set", int'(done), 1);
    chk("done_cnt", int'(move_count), 7);
    repeat (3) tick();
    chk("done_hold", int'(done), 1);
    chk("done_hold_cnt", int'(move_count), 7);
    chk("done_hold_vld", int'(mv_if.move_valid), 0);

    // Restart from DONE with ring 1 on peg 2 to exercise the rightward wrap.
    peg[0] = 0; peg[1] = 2; peg[2] = 0;
    drive_rings();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_done", int'(done), 0);
    chk("restart_cnt", int'(move_count), 1);
    chk("restart_vld", int'(mv_if.move_valid), 0);
    tick();
    chk("restart_offer", int'(mv_if.move_valid), 1);
    take(0, 2, 1);
    take(1, 0, 2);

    rst = 1'b0;
    tick();
    chk_reset("endrst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
